// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: receives a length-prefixed byte
// frame from the host link, writes little-endian 32-bit words to
// consecutive word addresses from 0, and releases the CPU only after the
// data checksum matches.
module imem_loader #(
  parameter int unsigned addrSize = 32,
  parameter int unsigned dataSize = 32,
  parameter int unsigned maxWords = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                in_valid,
  input  logic [7:0]          in_data,
  output logic                in_ready,
  output logic                wr_en,
  output logic [addrSize-1:0] wr_addr,
  output logic [dataSize-1:0] wr_data,
  output logic                cpu_hold,
  output logic                done,
  output logic                error,
  output logic [15:0]         word_count
);

  localparam int unsigned LenW   = 16;
  localparam int unsigned ByteW  = 8;
  localparam int unsigned PartW  = 24;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    CSUM   = 3'd4,
    DONE   = 3'd5,
    ERROR  = 3'd6
  } state_e;

  state_e              state_q, state_d;
  logic [ByteW-1:0]    len_lo_q, len_lo_d;
  logic [LenW-1:0]     len_q, len_d;
  logic [PartW-1:0]    word_buf_q, word_buf_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [ByteW-1:0]    csum_q, csum_d;
  logic [LenW-1:0]     word_count_q, word_count_d;
  logic                in_ready_q, in_ready_d;
  logic                wr_en_q, wr_en_d;
  logic [addrSize-1:0] wr_addr_q, wr_addr_d;
  logic [dataSize-1:0] wr_data_q, wr_data_d;
  logic                cpu_hold_q, cpu_hold_d;
  logic                done_q, done_d;
  logic                error_q, error_d;

  logic                accept_c;
  logic [LenW-1:0]     len_rx_c;
  logic [LenW-1:0]     count_inc_c;

  assign accept_c    = in_valid && in_ready_q;
  assign len_rx_c    = {in_data, len_lo_q};
  assign count_inc_c = word_count_q + LenW'(1);

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d      = state_q;
    len_lo_d     = len_lo_q;
    len_d        = len_q;
    word_buf_d   = word_buf_q;
    byte_cnt_d   = byte_cnt_q;
    csum_d       = csum_q;
    word_count_d = word_count_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    cpu_hold_d   = cpu_hold_q;
    done_d       = done_q;
    error_d      = error_q;

    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d      = LEN_LO;
          word_count_d = '0;
          done_d       = 1'b0;
          error_d      = 1'b0;
          csum_d       = '0;
          byte_cnt_d   = '0;
          cpu_hold_d   = 1'b1;
        end
      end
      LEN_LO: begin
        if (accept_c) begin
          len_lo_d = in_data;
          state_d  = LEN_HI;
        end
      end
      LEN_HI: begin
        if (accept_c) begin
          len_d = len_rx_c;
          if (32'(len_rx_c) > maxWords) begin
            state_d = ERROR;
            error_d = 1'b1;
          end else if (len_rx_c == '0) begin
            state_d = CSUM;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (accept_c) begin
          csum_d     = csum_q ^ in_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd0: word_buf_d[7:0]   = in_data;
            2'd1: word_buf_d[15:8]  = in_data;
            2'd2: word_buf_d[23:16] = in_data;
            default: begin
              wr_en_d      = 1'b1;
              wr_data_d    = dataSize'({in_data, word_buf_q});
              wr_addr_d    = addrSize'({word_count_q, 2'b00});
              word_count_d = count_inc_c;
              if (count_inc_c == len_q) begin
                state_d = CSUM;
              end
            end
          endcase
        end
      end
      CSUM: begin
        if (accept_c) begin
          if (in_data == csum_q) begin
            state_d    = DONE;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end else begin
            state_d    = ERROR;
            error_d    = 1'b1;
            cpu_hold_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d = (state_d == LEN_LO) || (state_d == LEN_HI) ||
                 (state_d == DATA)   || (state_d == CSUM);
  end

  // State and output registers; reset abandons any load in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      len_lo_q     <= '0;
      len_q        <= '0;
      word_buf_q   <= '0;
      byte_cnt_q   <= '0;
      csum_q       <= '0;
      word_count_q <= '0;
      in_ready_q   <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      cpu_hold_q   <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_lo_q     <= len_lo_d;
      len_q        <= len_d;
      word_buf_q   <= word_buf_d;
      byte_cnt_q   <= byte_cnt_d;
      csum_q       <= csum_d;
      word_count_q <= word_count_d;
      in_ready_q   <= in_ready_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      cpu_hold_q   <= cpu_hold_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign cpu_hold   = cpu_hold_q;
  assign done       = done_q;
  assign error      = error_q;
  assign word_count = word_count_q;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the writable instruction memory of the ARM pipeline. The IF stage remains the reader of that memory.
- Accepts a byte stream from a host link (UART/JTAG bridge) through a valid/ready handshake.
- Assembles little-endian 32-bit instruction words and writes them to consecutive word addresses starting at 0.
- Holds the CPU in reset until a complete program with a valid checksum has been loaded.

Parameters:
- addrSize, 32, width of the byte address driven to the instruction memory write port.
- dataSize, 32, instruction word width. Fixed at 4 bytes per word.
- maxWords, 64, capacity of the instruction memory in words. Larger length fields are rejected.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a load. Honoured only in IDLE, DONE or ERROR.
- in_valid  in  1  host byte valid.
- in_data  in  8  host byte.
- in_ready  out  1  loader can accept a byte.
- wr_en  out  1  instruction memory write strobe, one cycle per word.
- wr_addr  out  addrSize  byte address of the word: word_index*4.
- wr_data  out  dataSize  assembled instruction word.
- cpu_hold  out  1  holds the CPU/PC in reset while high.
- done  out  1  load completed with a good checksum.
- error  out  1  load aborted: bad length or bad checksum.
- word_count  out  16  number of words written so far.

Behaviour:
- Reset values (applied asynchronously while rst=0):
  - state=IDLE; in_ready=0, wr_en=0, wr_addr=0, wr_data=0, done=0, error=0, word_count=0.
  - cpu_hold=1.
  - Asserting reset mid-load abandons the load. Memory contents already written are not cleared.
- Byte transfer occurs on a rising edge when in_valid && in_ready. in_ready is a registered function of state only.
  - in_ready=1 in LEN_LO, LEN_HI, DATA, CSUM.
  - in_ready=0 in IDLE, DONE, ERROR.
- Frame format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4*N data bytes LSB first, then one checksum byte.
  - The checksum is the XOR of all data bytes only; length bytes are excluded.
- State machine:
  - IDLE: start -> LEN_LO. Clears word_count, done, error and the checksum accumulator; sets cpu_hold=1.
  - LEN_LO: accept byte -> LEN_HI.
  - LEN_HI: accept byte, then branch on N:
    - N > maxWords -> ERROR.
    - N == 0 -> CSUM.
    - otherwise -> DATA.
  - DATA: shift each accepted byte into byte lane byte_cnt (0..3), with byte 0 in bits [7:0].
    - On the 4th byte, the next cycle has wr_en=1, wr_data=word, wr_addr=word_index<<2.
    - word_count increments in that same cycle.
    - After word N-1 is accepted -> CSUM.
    - wr_en never asserts on consecutive cycles.
  - CSUM: accept byte.
    - Equals the accumulator -> DONE.
    - Otherwise -> ERROR.
  - DONE: done=1, cpu_hold=0. start -> LEN_LO (re-load, cpu_hold=1 again).
  - ERROR: error=1, cpu_hold=1. start -> LEN_LO.
- start outside IDLE/DONE/ERROR is ignored.
- in_valid stalls for any number of cycles are legal. Partial-word state is held across stalls.
- wr_addr wraps at addrSize bits. This is unreachable because N <= maxWords.
- Latency: last byte of a word to wr_en is 1 cycle. CSUM byte accept to done/error is 1 cycle.

Test Plan:
- Nominal load:
  - Stimulus: rst, start, bytes 02 00 14 00 A0 E3 FF FF FF EA 42 with in_valid held high.
  - Required: wr_en pulses with (addr 0, 0xE3A00014) and (addr 4, 0xEAFFFFFF).
  - Required: word_count=2, done=1, cpu_hold=0, error=0.
- Bad checksum:
  - Stimulus: same frame with last byte 43.
  - Required: both writes occur, then error=1, done=0, cpu_hold=1. A later start restarts at LEN_LO.
- Oversize length:
  - Stimulus: length 41 00 (65 > maxWords).
  - Required: ERROR after LEN_HI, no wr_en pulses, in_ready=0.
- Zero length:
  - Stimulus: 00 00 then 00.
  - Required: done=1, word_count=0, no writes.
- Backpressure / stall:
  - Stimulus: random in_valid gaps of 0–5 cycles during the nominal frame.
  - Required: identical writes and result. start pulsed mid-DATA is ignored.
- Reset mid-load:
  - Stimulus: rst low after 5 data bytes.
  - Required: immediately state=IDLE, in_ready=0, cpu_hold=1, word_count=0. A fresh full load then succeeds.
